// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Optional macro DIV_ZERO_TRAP_EN short-circuits a zero divisor to a one-cycle result with div_by_zero set.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] count_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] r_d;

    // The partial remainder always stays below the divisor, so WIDTH bits hold it;
    // the trial subtraction carries the extra bit whose sign selects restore.
    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        trial   = r_shift - {1'b0, d_q};
        q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        r_d     = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIV_ZERO_TRAP_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_q     <= dividend;
                        r_q     <= '0;
                        d_q     <= divisor;
                        count_q <= '0;
`ifdef DIV_ZERO_TRAP_EN
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                            state_q     <= RUN;
                            busy        <= 1'b1;
                        end
`else
                        state_q <= RUN;
                        busy    <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    q_q     <= q_d;
                    r_q     <= r_d;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_d;
                        remainder <= r_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef DIV_ZERO_TRAP_EN
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=4), both DIV_ZERO_TRAP_EN builds.
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 4;

`ifdef DIV_ZERO_TRAP_EN
    localparam int unsigned DZ_LAT = 1;
    localparam int unsigned DZ_FLAG = 1;
`else
    localparam int unsigned DZ_LAT = 5;
    localparam int unsigned DZ_FLAG = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge; returns one cycle after the accepting edge.
    task automatic start_op(input int unsigned a, input int unsigned b);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Bounded wait for done; cyc is the cycle (counted from the start cycle) in which done is seen.
    task automatic wait_done(output int unsigned cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("done_seen", 32'(done), 1);
    endtask

    task automatic count_dones(input int unsigned n, output int unsigned cnt);
        cnt = 0;
        for (int i = 0; i < int'(n); i++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int unsigned lat;
        int unsigned cnt;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quot", 32'(quotient), 0);
        check("rst_rem", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        rst = 1'b0;
        tick();

        // 13/3: busy cycles 1..4, done in cycle 5 only
        start_op(13, 3);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 1);
            check($sformatf("t1_done_c%0d", c), 32'(done), 0);
            tick();
        end
        check("t1_done", 32'(done), 1);
        check("t1_busy_off", 32'(busy), 0);
        check("t1_quot", 32'(quotient), 4);
        check("t1_rem", 32'(remainder), 1);
        check("t1_dbz", 32'(div_by_zero), 0);
        tick();
        check("t1_done_pulse", 32'(done), 0);

        // 15/1 then 5/7 started in the done cycle
        start_op(15, 1);
        wait_done(lat);
        check("t2a_lat", lat, 5);
        check("t2a_quot", 32'(quotient), 15);
        check("t2a_rem", 32'(remainder), 0);
        start_op(5, 7);
        check("t2b_busy", 32'(busy), 1);
        check("t2b_hold_quot", 32'(quotient), 15);
        check("t2b_done_low", 32'(done), 0);
        wait_done(lat);
        check("t2b_lat", lat, 5);
        check("t2b_quot", 32'(quotient), 0);
        check("t2b_rem", 32'(remainder), 5);

        // 9/0
        start_op(9, 0);
        check("t3_busy_c1", 32'(busy), (DZ_LAT == 1) ? 0 : 1);
        wait_done(lat);
        check("t3_lat", lat, DZ_LAT);
        check("t3_quot", 32'(quotient), 15);
        check("t3_rem", 32'(remainder), 9);
        check("t3_dbz", 32'(div_by_zero), DZ_FLAG);
        tick();

        // 12/4 with an ignored start of 7/2 in cycle 2
        start_op(12, 4);
        check("t4_dbz_clear", 32'(div_by_zero), 0);
        tick();
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        check("t4_done", 32'(done), 1);
        check("t4_quot", 32'(quotient), 3);
        check("t4_rem", 32'(remainder), 0);
        count_dones(8, cnt);
        check("t4_no_second_done", cnt, 0);

        // 14/5 abandoned by async reset in cycle 3
        start_op(14, 5);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_quot", 32'(quotient), 0);
        check("t5_rst_rem", 32'(remainder), 0);
        check("t5_rst_dbz", 32'(div_by_zero), 0);
        tick();
        rst = 1'b0;
        count_dones(8, cnt);
        check("t5_no_done", cnt, 0);
        start_op(14, 5);
        wait_done(lat);
        check("t5_lat", lat, 5);
        check("t5_quot", 32'(quotient), 2);
        check("t5_rem", 32'(remainder), 4);

        // Sweep of every nonzero-divisor pair, launched back to back
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                start_op(a, b);
                wait_done(lat);
                check($sformatf("sweep_q %0d/%0d", a, b), 32'(quotient), 32'(a / b));
                check($sformatf("sweep_r %0d/%0d", a, b), 32'(remainder), 32'(a % b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
